fp_prep: RTL
============

// Module: fp_prep
// PURPOSE
//  Operand front end for the fp_max/fp_cmp datapath: accepts raw operands, classifies them, and builds the 65-bit sign/magnitude extensions.
//  Outputs feed the fp_max/compare consumers directly.
//  Pipelined, valid/ready on both sides, one pair per cycle, synchronous flush.
// PARAMETERS
//  STAGES   2   pipeline depth; 1 = classify combinationally from stage-1 regs, 2 = classify results registered in stage 2
// PORTS
//  clock       in   1   single clock, all state on posedge
//  reset       in   1   asynchronous, active-high; clears all state
//  flush       in   1   synchronous kill of all in-flight pairs
//  in_valid    in   1   request valid
//  in_ready    out  1   request accepted when in_valid & in_ready
//  in_data1    in   64  operand 1 (single: bits 31:0, NaN-boxed)
//  in_data2    in   64  operand 2
//  in_fmt      in   2   0 = single, 1 = double, 2/3 reserved
//  in_rm       in   3   passed through untouched
//  out_valid   out  1   result valid
//  out_ready   in   1   consumer takes result when out_valid & out_ready
//  out_data1/2 out  64  operands, passed through
//  out_ext1/2  out  65  {sign, magnitude}
//  out_class1/2 out 10  RISC-V fclass one-hot: 0 -inf, 1 -norm, 2 -sub, 3 -0, 4 +0, 5 +sub, 6 +norm, 7 +inf, 8 sNaN, 9 qNaN
//  out_fmt     out  2   passed through
//  out_rm      out  3   passed through
// BEHAVIOUR
//  - Reset: out_valid = 0, all stage valids = 0, all data/ext/class regs = 0; in_ready = 1 after reset.
//  - Stage k advances when empty, or when stage k+1 advances (last stage: when out_ready).
//  - in_ready = ~flush & (~s1_valid | s1_advance). Full throughput with out_ready held high.
//  - Latency from accept to out_valid is STAGES cycles.
//  - Stall: while out_valid & ~out_ready, every out_* is held stable; no pair is dropped or duplicated.
//  - Flush: at the next edge, all valids clear and any in_valid that cycle is not accepted. Flush has priority over accept and over a simultaneous out handshake. Data regs keep their contents.
//  - Reset mid-transfer: in-flight pairs are discarded asynchronously and out_valid drops immediately.
//  - Single (fmt 0): s = d[31], e = d[30:23], m = d[22:0]; ext = {s, 33'b0, d[30:0]}.
//  - Double (fmt 1): s = d[63], e = d[62:52], m = d[51:0]; ext = {s, 1'b0, d[62:0]}.
//  - The ext magnitude order matches IEEE magnitude order, so consumers compare ext[63:0] unsigned.
//  - class:
//    - e = all-ones, m = 0 -> inf (by sign).
//    - e = all-ones, m != 0, m msb = 1 -> qNaN (bit 9); m msb = 0 -> sNaN (bit 8).
//    - e = 0, m = 0 -> zero (by sign); e = 0, m != 0 -> subnormal.
//    - otherwise normal. Exactly one class bit is set.
//  - Reserved fmt 2/3: class = 10'h200, ext = 0.
// CONFIGURATION
//  FP_PREP_NANBOX_EN defined:
//   - For fmt 0 with d[63:32] != 32'hffffffff, the operand is replaced by 64'h000000007fc00000 before classification.
//   - It then classifies as qNaN and out_data carries the replacement.
//  FP_PREP_NANBOX_EN undefined: d[63:32] is ignored for fmt 0 and out_data passes through unchanged.
// STRUCTURE
//  - fp_wire package additions:
//    - fp_prep_in_type {data1, data2, fmt, rm}
//    - fp_prep_out_type {data1, data2, ext1, ext2, class1, class2, fmt, rm}
//    - constant FP_QNAN_S = 64'h000000007fc00000, FP_QNAN_D = 64'h7ff8000000000000
//  - Sub-module fp_prep_class: combinational, one operand + fmt -> {ext, class}. Instantiated twice, fed from stage-1 regs.
// TESTING
//  - Reset asserted with s1 full -> out_valid = 0 immediately. After release, in_ready = 1.
//  - fmt 1: d1 = 64'h3ff0000000000000, d2 = 64'hfff0000000000000, STAGES=2, out_ready = 1.
//    -> out_valid 2 cycles after accept.
//    -> class1 = 10'h040, class2 = 10'h001, ext2 = {1, 64'h7ff0000000000000}.
//  - fmt 0: d1 = ffffffff_7f800001 -> class1 = 10'h100 (sNaN). d2 = ffffffff_00000001 -> class2 = 10'h020.
//  - Stream 4 pairs, out_ready low 3 cycles mid-stream -> outputs held, in_ready drops when full, all 4 emerge in order, none lost.
//  - flush together with in_valid and out_valid&out_ready -> pair not accepted, out_valid = 0 next cycle.
//  - FP_PREP_NANBOX_EN: fmt 0, d1 = 00000000_3f800000 -> out_data1 = 000000007fc00000, class1 = 10'h200. Without the macro -> class1 = 10'h040.

Source files
------------

// File: rtl/fp_wire.sv
// fp_wire: shared operand/result records and NaN constants for the fp_prep front end
package fp_wire;

    localparam logic [1:0]  FMT_S     = 2'd0;
    localparam logic [1:0]  FMT_D     = 2'd1;
    localparam logic [63:0] FP_QNAN_S = 64'h000000007fc00000;
    localparam logic [63:0] FP_QNAN_D = 64'h7ff8000000000000;

    typedef struct packed {
        logic [63:0] data1;
        logic [63:0] data2;
        logic [1:0]  fmt;
        logic [2:0]  rm;
    } fp_prep_in_type;

    typedef struct packed {
        logic [63:0] data1;
        logic [63:0] data2;
        logic [64:0] ext1;
        logic [64:0] ext2;
        logic [9:0]  class1;
        logic [9:0]  class2;
        logic [1:0]  fmt;
        logic [2:0]  rm;
    } fp_prep_out_type;

    // a single-precision operand whose upper word is not all ones is not a valid boxed value
    function automatic logic [63:0] fp_nanbox(input logic [63:0] d, input logic [1:0] fmt);
        return (fmt == FMT_S && d[63:32] != 32'hffffffff) ? FP_QNAN_S : d;
    endfunction

endpackage

// File: rtl/fp_prep_class.sv
// fp_prep_class: classifies one operand (fclass one-hot) and builds its 65-bit sign/magnitude extension
module fp_prep_class
    import fp_wire::*;
(
    input  logic [63:0] data_i,
    input  logic [1:0]  fmt_i,
    output logic [64:0] ext_o,
    output logic [9:0]  class_o
);

    logic sgl, rsv, s, e_max, e_zero, m_zero, m_msb, inf, nan, zero, sub, norm;

    // field decode and one-hot class; reserved formats report qNaN with a zero extension
    always_comb begin
        sgl     = fmt_i == FMT_S;
        rsv     = fmt_i[1];
        s       = sgl ? data_i[31] : data_i[63];
        e_max   = sgl ? &data_i[30:23] : &data_i[62:52];
        e_zero  = sgl ? ~|data_i[30:23] : ~|data_i[62:52];
        m_zero  = sgl ? ~|data_i[22:0] : ~|data_i[51:0];
        m_msb   = sgl ? data_i[22] : data_i[51];
        inf     = e_max & m_zero;
        nan     = e_max & ~m_zero;
        zero    = e_zero & m_zero;
        sub     = e_zero & ~m_zero;
        norm    = ~e_max & ~e_zero;
        class_o = rsv ? 10'h200 : {nan & m_msb, nan & ~m_msb, ~s & inf, ~s & norm, ~s & sub,
                                   ~s & zero, s & zero, s & sub, s & norm, s & inf};
        ext_o   = rsv ? 65'b0 : sgl ? {data_i[31], 33'b0, data_i[30:0]} : {data_i[63], 1'b0, data_i[62:0]};
    end

endmodule

// File: rtl/fp_prep.sv
// fp_prep: pipelined operand front end (classify + sign/magnitude extension); FP_PREP_NANBOX_EN replaces unboxed singles with qNaN
module fp_prep
    import fp_wire::*;
#(
    parameter int STAGES = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [63:0] in_data1_i,
    input  logic [63:0] in_data2_i,
    input  logic [1:0]  in_fmt_i,
    input  logic [2:0]  in_rm_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] out_data1_o,
    output logic [63:0] out_data2_o,
    output logic [64:0] out_ext1_o,
    output logic [64:0] out_ext2_o,
    output logic [9:0]  out_class1_o,
    output logic [9:0]  out_class2_o,
    output logic [1:0]  out_fmt_o,
    output logic [2:0]  out_rm_o
);

    fp_prep_in_type  in_w, s1_q, s1_d;
    fp_prep_out_type cls_w, out_w;
    logic            s1_valid_q, s1_valid_d, s1_adv, nxt_adv, out_valid;
    logic [64:0]     ext1_w, ext2_w;
    logic [9:0]      class1_w, class2_w;

`ifdef FP_PREP_NANBOX_EN
    assign in_w = '{data1: fp_nanbox(in_data1_i, in_fmt_i), data2: fp_nanbox(in_data2_i, in_fmt_i),
                    fmt: in_fmt_i, rm: in_rm_i};
`else
    assign in_w = '{data1: in_data1_i, data2: in_data2_i, fmt: in_fmt_i, rm: in_rm_i};
`endif

    assign s1_adv     = ~s1_valid_q | nxt_adv;
    assign in_ready_o = ~flush_i & s1_adv;

    // stage 1 next state: flush empties it, an accepted pair loads, otherwise hold
    always_comb begin
        s1_valid_d = flush_i ? 1'b0 : (s1_adv ? in_valid_i : s1_valid_q);
        s1_d       = (in_valid_i & in_ready_o) ? in_w : s1_q;
    end

    // stage 1 registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
        end
    end

    fp_prep_class u_class1 (.data_i(s1_q.data1), .fmt_i(s1_q.fmt), .ext_o(ext1_w), .class_o(class1_w));
    fp_prep_class u_class2 (.data_i(s1_q.data2), .fmt_i(s1_q.fmt), .ext_o(ext2_w), .class_o(class2_w));

    assign cls_w = '{data1: s1_q.data1, data2: s1_q.data2, ext1: ext1_w, ext2: ext2_w,
                     class1: class1_w, class2: class2_w, fmt: s1_q.fmt, rm: s1_q.rm};

    generate
        if (STAGES == 1) begin : g_one
            assign nxt_adv   = out_ready_i;
            assign out_valid = s1_valid_q;
            assign out_w     = cls_w;
        end else begin : g_two
            fp_prep_out_type s2_q, s2_d;
            logic            s2_valid_q, s2_valid_d, s2_adv;

            assign s2_adv  = ~s2_valid_q | out_ready_i;
            assign nxt_adv = s2_adv;

            // stage 2 next state: captures the classified stage-1 pair when it moves on
            always_comb begin
                s2_valid_d = flush_i ? 1'b0 : (s2_adv ? s1_valid_q : s2_valid_q);
                s2_d       = (~flush_i & s2_adv & s1_valid_q) ? cls_w : s2_q;
            end

            // stage 2 registers
            always_ff @(posedge clock_i or posedge reset_i) begin
                if (reset_i) begin
                    s2_valid_q <= 1'b0;
                    s2_q       <= '0;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    s2_q       <= s2_d;
                end
            end

            assign out_valid = s2_valid_q;
            assign out_w     = s2_q;
        end
    endgenerate

    assign out_valid_o  = out_valid;
    assign out_data1_o  = out_w.data1;
    assign out_data2_o  = out_w.data2;
    assign out_ext1_o   = out_w.ext1;
    assign out_ext2_o   = out_w.ext2;
    assign out_class1_o = out_w.class1;
    assign out_class2_o = out_w.class2;
    assign out_fmt_o    = out_w.fmt;
    assign out_rm_o     = out_w.rm;

endmodule
